// File: rtl/fpu_ret_pkg.sv
// Shared types and helpers for the FPU retire gather block.
package fpu_ret_pkg;

  localparam int NPORT         = 3;
  localparam int FPCSR_MASK_LO = 7;

  localparam int FL_INX = 0;
  localparam int FL_UNF = 1;
  localparam int FL_OVF = 2;
  localparam int FL_DZ  = 3;
  localparam int FL_INV = 4;
  localparam int FL_DEN = 5;
  localparam int FL_W   = FL_DEN + 1;

  typedef struct packed {
    logic [7:0]      tag;
    logic [FL_W-1:0] flags;
  } fpu_ret_t;

  // First requesting port at or after rr, wrapping modulo NPORT.
  function automatic logic [1:0] rr_pick(input logic [1:0] rr, input logic [NPORT-1:0] req);
    logic [1:0] pick;
    logic [2:0] s;
    logic       found;
    pick  = rr;
    found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      s = {1'b0, rr} + 3'(i);
      if (s >= 3'(NPORT)) s = s - 3'(NPORT);
      if (!found && req[s[1:0]]) begin
        pick  = s[1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'(NPORT - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fpu_ret_fifo.sv
// Per-port completion FIFO; head is read straight from storage so a word is visible the
// cycle after it is written. Pointers carry one extra wrap bit to tell full from empty.
module fpu_ret_fifo
  import fpu_ret_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  fpu_ret_t       din,
  output fpu_ret_t       dout,
  output logic           empty,
  output logic           full,
  output logic [PTR_W:0] count
);

  fpu_ret_t       mem_q [DEPTH];
  logic [PTR_W:0] wr_q, rd_q;
  logic           do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign count   = wr_q - rd_q;
  assign do_pop  = pop & ~empty;
  // When full, the write lands in the slot being vacated by a same-cycle pop.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/fpu_ret_gather.sv
// Gathers FPU completion words from three issue ports and retires them round-robin to the ROB,
// tracking sticky IEEE flags and trapping on unmasked ones. FPU_RET_BYPASS_EN adds a 0-cycle idle path.
module fpu_ret_gather
  import fpu_ret_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fpcsr,
  input  logic [13:0] u1_ret,
  input  logic        u1_ret_en,
  input  logic [13:0] u3_ret,
  input  logic        u3_ret_en,
  input  logic [13:0] u5_ret,
  input  logic        u5_ret_en,
  output logic        rt_valid,
  input  logic        rt_ready,
  output logic [7:0]  rt_tag,
  output logic [5:0]  rt_flags,
  output logic [1:0]  rt_port,
  output logic [5:0]  sticky,
  input  logic        sticky_clr,
  output logic        trap_req,
  output logic        ovf_err
);

  fpu_ret_t         in_w [NPORT];
  fpu_ret_t         head [NPORT];
  logic [PTR_W:0]   cnt  [NPORT];
  logic [NPORT-1:0] in_en, push, pop, empty, full;

  assign in_w[0] = u1_ret;
  assign in_w[1] = u3_ret;
  assign in_w[2] = u5_ret;
  assign in_en   = {u5_ret_en, u3_ret_en, u1_ret_en};

  for (genvar g = 0; g < NPORT; g++) begin : g_fifo
    fpu_ret_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (in_w[g]),
      .dout  (head[g]),
      .empty (empty[g]),
      .full  (full[g]),
      .count (cnt[g])
    );
  end

  logic [1:0]      rr_q, rr_d, lock_port_q, lock_port_d;
  logic            lock_q, lock_d;
  logic [FL_W-1:0] sticky_q, sticky_d;
  logic            trap_q, trap_d, ovf_q, ovf_d;

  logic       any_ne, byp_act, valid, hs;
  logic [1:0] sel, byp_sel, cur_port;
  fpu_ret_t   cur_w;

  always_comb begin
    any_ne  = |(~empty);
    // A stalled presentation is pinned so a newly filled higher-priority port cannot preempt it.
    sel     = lock_q ? lock_port_q : rr_pick(rr_q, ~empty);
    byp_sel = rr_pick(rr_q, in_en);
    byp_act = 1'b0;
`ifdef FPU_RET_BYPASS_EN
    byp_act = ~any_ne & (|in_en);
`endif
    cur_port = byp_act ? byp_sel : sel;
    cur_w    = byp_act ? in_w[byp_sel] : head[sel];
    valid    = any_ne | byp_act;
    hs       = valid & rt_ready;

    pop = '0;
    if (hs && !byp_act) pop[sel] = 1'b1;

    push  = '0;
    ovf_d = ovf_q;
    for (int p = 0; p < NPORT; p++) begin
      push[p] = in_en[p] & (~full[p] | pop[p])
              & ~(byp_act & rt_ready & (byp_sel == 2'(p)));
      if (in_en[p] && (cnt[p] == (PTR_W+1)'(DEPTH)) && !pop[p]) ovf_d = 1'b1;
    end

    sticky_d = sticky_clr ? '0 : sticky_q;
    if (hs) sticky_d = sticky_d | cur_w.flags;
    trap_d = hs & (|(cur_w.flags & ~fpcsr[FPCSR_MASK_LO +: FL_W]));

    rr_d        = hs ? next_port(cur_port) : rr_q;
    lock_d      = valid & ~rt_ready;
    lock_port_d = cur_port;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
      sticky_q    <= '0;
      trap_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      sticky_q    <= sticky_d;
      trap_q      <= trap_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rt_valid = valid;
  assign rt_tag   = valid ? cur_w.tag   : '0;
  assign rt_flags = valid ? cur_w.flags : '0;
  assign rt_port  = valid ? cur_port    : '0;
  assign sticky   = sticky_q;
  assign trap_req = trap_q;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_fpu_ret_gather.sv
// Self-checking bench for fpu_ret_gather: directed scenarios plus a random phase against a queue model.
module tb_fpu_ret_gather;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fpcsr;
  logic [13:0] u1_ret, u3_ret, u5_ret;
  logic        u1_ret_en, u3_ret_en, u5_ret_en;
  logic        rt_valid, rt_ready;
  logic [7:0]  rt_tag;
  logic [5:0]  rt_flags, sticky;
  logic [1:0]  rt_port;
  logic        sticky_clr, trap_req, ovf_err;

  always #5 clk = ~clk;

  fpu_ret_gather #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .fpcsr(fpcsr),
    .u1_ret(u1_ret), .u1_ret_en(u1_ret_en),
    .u3_ret(u3_ret), .u3_ret_en(u3_ret_en),
    .u5_ret(u5_ret), .u5_ret_en(u5_ret_en),
    .rt_valid(rt_valid), .rt_ready(rt_ready),
    .rt_tag(rt_tag), .rt_flags(rt_flags), .rt_port(rt_port),
    .sticky(sticky), .sticky_clr(sticky_clr),
    .trap_req(trap_req), .ovf_err(ovf_err)
  );

  int tests = 0;
  int fails = 0;
  int retired = 0;

  logic [13:0] mq [3][$];
  int          rr_m, hport_m;
  logic        held_m, trap_m, ovf_m;
  logic [5:0]  sticky_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int rr, input logic [2:0] m);
    int k;
    for (int i = 0; i < 3; i++) begin
      k = (rr + i) % 3;
      if (m[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    rr_m = 0; hport_m = 0; held_m = 0; trap_m = 0; ovf_m = 0; sticky_m = '0;
  endtask

  task automatic idle();
    u1_ret_en = 0; u3_ret_en = 0; u5_ret_en = 0; sticky_clr = 0;
  endtask

  // One clock: check presented outputs at the negedge, then advance the model.
  task automatic step();
    logic [2:0]  ne, arr;
    logic [13:0] rin [3];
    logic [13:0] w;
    logic        v, hs, byp;
    int          p;
    @(negedge clk);
    rin[0] = u1_ret; rin[1] = u3_ret; rin[2] = u5_ret;
    arr = {u5_ret_en, u3_ret_en, u1_ret_en};
    for (int i = 0; i < 3; i++) ne[i] = (mq[i].size() != 0);
    byp = 0; v = 0; p = 0; w = '0;
    if (ne != 0) begin
      v = 1; p = held_m ? hport_m : pick(rr_m, ne); w = mq[p][0];
    end
`ifdef FPU_RET_BYPASS_EN
    else if (arr != 0) begin
      v = 1; byp = 1; p = pick(rr_m, arr); w = rin[p];
    end
`endif
    check("rt_valid", 32'(rt_valid), 32'(v));
    check("rt_tag",   32'(rt_tag),   32'(w[13:6]));
    check("rt_flags", 32'(rt_flags), 32'(w[5:0]));
    check("rt_port",  32'(rt_port),  32'(p));
    check("sticky",   32'(sticky),   32'(sticky_m));
    check("trap_req", 32'(trap_req), 32'(trap_m));
    check("ovf_err",  32'(ovf_err),  32'(ovf_m));
    hs = v & rt_ready;
    trap_m = hs && ((w[5:0] & ~fpcsr[12:7]) != 0);
    if (sticky_clr) sticky_m = '0;
    if (hs) begin
      sticky_m |= w[5:0];
      if (!byp) void'(mq[p].pop_front());
      rr_m = (p + 1) % 3;
      retired++;
    end
    held_m = v & !rt_ready; hport_m = p;
    for (int i = 0; i < 3; i++) begin
      if (arr[i]) begin
        if (byp && hs && i == p) ;
        else if (mq[i].size() < DEPTH) mq[i].push_back(rin[i]);
        else ovf_m = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    logic [7:0] t0;
    rst = 1; fpcsr = '0; rt_ready = 0;
    u1_ret = '0; u3_ret = '0; u5_ret = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rt_valid), 0);
    check("rst_tag",   32'(rt_tag),   0);
    check("rst_port",  32'(rt_port),  0);
    check("rst_stky",  32'(sticky),   0);
    check("rst_trap",  32'(trap_req), 0);
    check("rst_ovf",   32'(ovf_err),  0);
    rst = 0;

    // 1: single word, all masked
    fpcsr[12:7] = 6'h3F; rt_ready = 1;
    u1_ret = {8'h2A, 6'b000001}; u1_ret_en = 1;
    step();
    idle();
    @(negedge clk);
    check("t1_valid", 32'(rt_valid), 1);
    check("t1_tag",   32'(rt_tag),   32'h2A);
    check("t1_port",  32'(rt_port),  0);
    @(posedge clk); #1;
    // model already advanced past the arrival; replay that handshake in the model
    void'(mq[0].pop_front()); sticky_m = 6'h01; rr_m = 1; retired++;
    check("t1_sticky", 32'(sticky), 32'h01);
    check("t1_trap",   32'(trap_req), 0);
    step();

    // 2: unmasked overflow flag on u3
    fpcsr[12:7] = 6'h3B;
    u3_ret = {8'h55, 6'b000100}; u3_ret_en = 1;
    step();
    idle();
    step();
    check("t2_trap",  32'(trap_req), 1);
    check("t2_stky2", 32'(sticky[2]), 1);
    step();
    check("t2_trap_off", 32'(trap_req), 0);

    // 3: round-robin across all ports
    base = retired;
    for (int c = 0; c < 4; c++) begin
      u1_ret = {8'(8'h10 + c), 6'b0}; u3_ret = {8'(8'h20 + c), 6'b0}; u5_ret = {8'(8'h30 + c), 6'b0};
      u1_ret_en = 1; u3_ret_en = 1; u5_ret_en = 1;
      step();
    end
    idle();
    repeat (10) step();
    check("t3_count", 32'(retired - base), 12);
    check("t3_noovf", 32'(ovf_err), 0);

    // 4: overflow on u5
    rt_ready = 0;
    for (int c = 0; c < 5; c++) begin
      u5_ret = {8'(8'h40 + c), 6'b0}; u5_ret_en = 1;
      step();
    end
    idle();
    check("t4_ovf", 32'(ovf_err), 1);
    base = retired; rt_ready = 1;
    repeat (6) step();
    check("t4_count", 32'(retired - base), 4);

    // 5: stall hold, late arrivals must not preempt; sticky_clr with handshake
    rt_ready = 0;
    u3_ret = {8'h77, 6'b100000}; u3_ret_en = 1;
    step();
    idle();
    t0 = rt_tag;
    u1_ret = {8'h78, 6'b000011}; u1_ret_en = 1;
    step();
    idle();
    step(); step();
    check("t5_hold", 32'(rt_tag), 32'(t0));
    rt_ready = 1; sticky_clr = 1;
    step();
    sticky_clr = 0;
    check("t5_sticky", 32'(sticky), 32'b100000);
    repeat (3) step();

    // 6: async reset with queued words
    rt_ready = 0; fpcsr[12:7] = 6'h00;
    u1_ret = {8'h91, 6'h01}; u3_ret = {8'h92, 6'h02}; u5_ret = {8'h93, 6'h04};
    u1_ret_en = 1; u3_ret_en = 1; u5_ret_en = 1;
    step();
    idle();
    rst = 1; #1;
    check("t6_valid_async", 32'(rt_valid), 0);
    model_reset();
    #1 rst = 0;
    rt_ready = 1;
    repeat (3) step();
`ifdef FPU_RET_BYPASS_EN
    u1_ret = {8'hB0, 6'h00}; u1_ret_en = 1; #1;
    check("t6_bypass", 32'(rt_valid), 1);
    step();
    idle();
    step();
`endif

    // random phase
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) fpcsr = $urandom;
      u1_ret = 14'($urandom); u3_ret = 14'($urandom); u5_ret = 14'($urandom);
      u1_ret_en = ($urandom_range(0, 2) == 0);
      u3_ret_en = ($urandom_range(0, 2) == 0);
      u5_ret_en = ($urandom_range(0, 2) == 0);
      rt_ready   = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    idle(); rt_ready = 1;
    repeat (15) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
